mmcm_drp_seq: RTL and testbench

- Sequences run-time reconfiguration of the 300 MHz-input MMCM clock generator through its DRP port, so the clk_out frequency can change without a new bitstream.
- On request, it holds the MMCM in reset and runs a read-modify-write over a table of DRP registers for the selected configuration.
- It then releases reset, waits for LOCKED, and reports done/error to the host (PS-side register block).

---
 rtl/mmcm_drp_seq.sv | 221 ++++++++++++++++++++++
 tb/tb_mmcm_drp_seq.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmcm_drp_seq.sv
// DRP read-modify-write sequencer for MMCM run-time reconfiguration.
// Optional readback verify of every write is enabled by defining MMCM_DRP_VERIFY_EN.
module mmcm_drp_seq #(
  parameter int NUM_REGS     = 23,
  parameter int CFG_W        = 2,
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 65535,
  localparam int IDX_W       = $clog2(NUM_REGS * (2 ** CFG_W))
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CFG_W-1:0] cfg_sel,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] tbl_idx,
  input  logic [38:0]      tbl_data,
  output logic [6:0]       drp_daddr,
  output logic             drp_den,
  output logic             drp_dwe,
  output logic [15:0]      drp_di,
  input  logic [15:0]      drp_do,
  input  logic             drp_drdy,
  output logic             mmcm_rst,
  input  logic             mmcm_locked
);

  localparam int REG_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int DCNT_W = (DRDY_TIMEOUT > 1) ? $clog2(DRDY_TIMEOUT) : 1;
  localparam int LCNT_W = (LOCK_TIMEOUT > 4) ? $clog2(LOCK_TIMEOUT) : 2;

  localparam logic [REG_W-1:0]  REG_LAST    = REG_W'(NUM_REGS - 1);
  localparam logic [DCNT_W-1:0] DRDY_LAST   = DCNT_W'(DRDY_TIMEOUT - 1);
  localparam logic [LCNT_W-1:0] LOCK_LAST   = LCNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [LCNT_W-1:0] LOCK_IGNORE = LCNT_W'(2);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ASSERT_RST,
    S_FETCH,
    S_LOAD,
    S_READ,
    S_WAIT_RD,
    S_WRITE,
    S_WAIT_WR,
`ifdef MMCM_DRP_VERIFY_EN
    S_READBACK,
    S_WAIT_VF,
`endif
    S_NEXT,
    S_RELEASE,
    S_WAIT_LOCK,
    S_DONE
  } state_t;

  state_t              state;
  logic [REG_W-1:0]    reg_i;
  logic [DCNT_W-1:0]   drdy_cnt;
  logic [LCNT_W-1:0]   lock_cnt;
  logic [15:0]         ent_mask;
  logic [15:0]         ent_data;
  logic [15:0]         merge_val;
  logic                locked_s1;
  logic                locked_s2;

  // A set mask bit keeps the bit currently held in the DRP register.
  always_comb begin
    merge_val = (drp_do & ent_mask) | (ent_data & ~ent_mask);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked_s1 <= 1'b0;
      locked_s2 <= 1'b0;
    end else begin
      locked_s1 <= mmcm_locked;
      locked_s2 <= locked_s1;
    end
  end

  // DEN/DWE/done are single-cycle pulses, so they default low every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      tbl_idx   <= '0;
      drp_daddr <= '0;
      drp_den   <= 1'b0;
      drp_dwe   <= 1'b0;
      drp_di    <= '0;
      mmcm_rst  <= 1'b0;
      reg_i     <= '0;
      drdy_cnt  <= '0;
      lock_cnt  <= '0;
      ent_mask  <= '0;
      ent_data  <= '0;
    end else begin
      done    <= 1'b0;
      drp_den <= 1'b0;
      drp_dwe <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            tbl_idx  <= IDX_W'(cfg_sel) * IDX_W'(NUM_REGS);
            reg_i    <= '0;
            error    <= 1'b0;
            busy     <= 1'b1;
            mmcm_rst <= 1'b1;
            state    <= S_ASSERT_RST;
          end
        end
        S_ASSERT_RST: state <= S_FETCH;
        S_FETCH:      state <= S_LOAD;
        S_LOAD: begin
          drp_daddr <= tbl_data[38:32];
          ent_mask  <= tbl_data[31:16];
          ent_data  <= tbl_data[15:0];
          drp_den   <= 1'b1;
          state     <= S_READ;
        end
        S_READ: begin
          drdy_cnt <= '0;
          state    <= S_WAIT_RD;
        end
        S_WAIT_RD: begin
          if (drp_drdy) begin
            drp_di  <= merge_val;
            drp_den <= 1'b1;
            drp_dwe <= 1'b1;
            state   <= S_WRITE;
          end else if (drdy_cnt == DRDY_LAST) begin
            error    <= 1'b1;
            mmcm_rst <= 1'b0;
            state    <= S_RELEASE;
          end else begin
            drdy_cnt <= drdy_cnt + DCNT_W'(1);
          end
        end
        S_WRITE: begin
          drdy_cnt <= '0;
          state    <= S_WAIT_WR;
        end
        S_WAIT_WR: begin
          if (drp_drdy) begin
`ifdef MMCM_DRP_VERIFY_EN
            drp_den <= 1'b1;
            state   <= S_READBACK;
`else
            state   <= S_NEXT;
`endif
          end else if (drdy_cnt == DRDY_LAST) begin
            error    <= 1'b1;
            mmcm_rst <= 1'b0;
            state    <= S_RELEASE;
          end else begin
            drdy_cnt <= drdy_cnt + DCNT_W'(1);
          end
        end
`ifdef MMCM_DRP_VERIFY_EN
        S_READBACK: begin
          drdy_cnt <= '0;
          state    <= S_WAIT_VF;
        end
        // drp_di still holds the merged word that was just written.
        S_WAIT_VF: begin
          if (drp_drdy) begin
            if (drp_do != drp_di) begin
              error    <= 1'b1;
              mmcm_rst <= 1'b0;
              state    <= S_RELEASE;
            end else begin
              state <= S_NEXT;
            end
          end else if (drdy_cnt == DRDY_LAST) begin
            error    <= 1'b1;
            mmcm_rst <= 1'b0;
            state    <= S_RELEASE;
          end else begin
            drdy_cnt <= drdy_cnt + DCNT_W'(1);
          end
        end
`endif
        S_NEXT: begin
          if (reg_i == REG_LAST) begin
            mmcm_rst <= 1'b0;
            state    <= S_RELEASE;
          end else begin
            reg_i   <= reg_i + REG_W'(1);
            tbl_idx <= tbl_idx + IDX_W'(1);
            state   <= S_FETCH;
          end
        end
        S_RELEASE: begin
          lock_cnt <= '0;
          state    <= S_WAIT_LOCK;
        end
        // The first cycles after release can still show the pre-reset LOCKED level.
        S_WAIT_LOCK: begin
          if (locked_s2 && (lock_cnt >= LOCK_IGNORE)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else if (lock_cnt == LOCK_LAST) begin
            error <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            lock_cnt <= lock_cnt + LCNT_W'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmcm_drp_seq.sv
// Bench for mmcm_drp_seq: ROM, DRP slave and MMCM lock models plus a
// transaction-level reference of the expected DRP reads/writes.
module tb_mmcm_drp_seq;

  localparam int NREG  = 23;
  localparam int IDX_W = 7;

  typedef struct {
    logic [6:0]  addr;
    logic        we;
    logic [15:0] di;
  } txn_t;

  logic             clk;
  logic             rst;
  logic             start;
  logic [1:0]       cfg_sel;
  logic             busy;
  logic             done;
  logic             error;
  logic [IDX_W-1:0] tbl_idx;
  logic [38:0]      tbl_data;
  logic [6:0]       drp_daddr;
  logic             drp_den;
  logic             drp_dwe;
  logic [15:0]      drp_di;
  logic [15:0]      drp_do;
  logic             drp_drdy;
  logic             mmcm_rst;
  logic             mmcm_locked;

  int checks;
  int errors;
  int cyc;

  txn_t        exp_q[$];
  logic [15:0] ref_mem [128];
  int          cur_cfg;
  logic        mem_init_req;
  logic        no_resp_en;
  logic [6:0]  no_resp_addr;
  logic        never_lock;

  int   n_rd, n_wr, min_idx, max_idx;
  int   last_den_cyc, err_cyc, rel_cyc, done_cyc;
  logic mrst_at_err;
  logic outstanding, prev_busy, prev_err, prev_mrst;

  mmcm_drp_seq #(
    .NUM_REGS(NREG),
    .CFG_W(2),
    .DRDY_TIMEOUT(64),
    .LOCK_TIMEOUT(1000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .cfg_sel(cfg_sel),
    .busy(busy),
    .done(done),
    .error(error),
    .tbl_idx(tbl_idx),
    .tbl_data(tbl_data),
    .drp_daddr(drp_daddr),
    .drp_den(drp_den),
    .drp_dwe(drp_dwe),
    .drp_di(drp_di),
    .drp_do(drp_do),
    .drp_drdy(drp_drdy),
    .mmcm_rst(mmcm_rst),
    .mmcm_locked(mmcm_locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [38:0] romWord(input int idx);
    int c;
    int i;
    c = idx / NREG;
    i = idx % NREG;
    if (idx == 23) return {7'h08, 16'hF000, 16'h0041};
    return {7'(8 + i), 16'(i * 16'h0F0F + c * 16'h3000), 16'(c * 16'h1111 + i * 16'h0203)};
  endfunction

  function automatic logic [15:0] drpInit(input int a);
    if (a == 8) return 16'h1234;
    return 16'(a * 257) ^ 16'hA5A5;
  endfunction

  // Synchronous table ROM with one cycle of latency
  always @(posedge clk) tbl_data <= romWord(int'(tbl_idx));

  // DRP slave: DRDY three cycles after DEN, optionally silent for one address
  logic [15:0] drp_mem [128];
  logic        rsp_pend;
  int          rsp_dl;
  logic [15:0] rsp_data;
  always @(posedge clk) begin
    drp_drdy <= 1'b0;
    if (mem_init_req)
      for (int a = 0; a < 128; a++) drp_mem[a] <= drpInit(a);
    if (rsp_pend) begin
      if (rsp_dl <= 1) begin
        drp_drdy <= 1'b1;
        drp_do   <= rsp_data;
        rsp_pend <= 1'b0;
      end else begin
        rsp_dl <= rsp_dl - 1;
      end
    end
    if (drp_den && !(no_resp_en && drp_daddr == no_resp_addr)) begin
      rsp_pend <= 1'b1;
      rsp_dl   <= 2;
      if (drp_dwe) begin
        drp_mem[drp_daddr] <= drp_di;
        rsp_data <= 16'h0000;
      end else begin
        rsp_data <= drp_mem[drp_daddr];
      end
    end
  end

  // MMCM lock model: LOCKED rises 100 cycles after RST is released
  int lcnt;
  always @(posedge clk) begin
    if (mmcm_rst) begin
      lcnt        <= 0;
      mmcm_locked <= 1'b0;
    end else if (lcnt < 100) begin
      lcnt <= lcnt + 1;
    end else if (!never_lock) begin
      mmcm_locked <= 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkRange(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Builds the expected DRP traffic from the table and a shadow of DRP memory,
  // then issues a start pulse for the given configuration.
  task automatic applyStimulus(input int cfg, input int stall_i);
    logic [38:0] w;
    logic [6:0]  a;
    logic [15:0] m;
    for (int k = 0; k < 128; k++) ref_mem[k] = drpInit(k);
    for (int i = 0; i < NREG; i++) begin
      w = romWord(cfg * NREG + i);
      a = w[38:32];
      exp_q.push_back('{a, 1'b0, 16'h0000});
      if (i == stall_i) break;
      m = (ref_mem[a] & w[31:16]) | (w[15:0] & ~w[31:16]);
      exp_q.push_back('{a, 1'b1, m});
`ifdef MMCM_DRP_VERIFY_EN
      exp_q.push_back('{a, 1'b0, 16'h0000});
`endif
      ref_mem[a] = m;
    end
    cur_cfg = cfg;
    @(negedge clk);
    mem_init_req = 1'b1;
    @(negedge clk);
    mem_init_req = 1'b0;
    cfg_sel = 2'(cfg);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input int bound);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < bound);
    checkOutput("done_seen", done, 1);
  endtask

  // Per-cycle monitor comparing DRP traffic and status against the reference
  always @(negedge clk) begin
    txn_t t;
    if (rst) begin
      outstanding = 1'b0;
      prev_busy   = 1'b0;
      prev_err    = 1'b0;
      prev_mrst   = 1'b0;
    end else begin
      if (busy && !prev_busy) begin
        n_rd = 0;
        n_wr = 0;
        min_idx = 1000;
        max_idx = -1;
        outstanding = 1'b0;
      end
      if (drp_dwe) checkOutput("dwe_needs_den", drp_den, 1);
      if (drp_den) begin
        checkOutput("den_no_overlap", outstanding, 0);
        checkOutput("den_expected", exp_q.size() != 0, 1);
        if (drp_dwe && drp_daddr == 7'h08 && n_wr == 0 && cur_cfg == 1)
          checkOutput("merge_0x08", drp_di, 16'h1041);
        if (exp_q.size() != 0) begin
          t = exp_q.pop_front();
          checkOutput("den_addr", drp_daddr, t.addr);
          checkOutput("den_we", drp_dwe, t.we);
          if (t.we) checkOutput("den_di", drp_di, t.di);
        end
        if (drp_dwe) n_wr++;
        else n_rd++;
        last_den_cyc = cyc;
        outstanding = 1'b1;
      end
      if (drp_drdy) outstanding = 1'b0;
      if (busy) begin
        checkRange("tbl_idx_range", int'(tbl_idx), cur_cfg * NREG, cur_cfg * NREG + NREG - 1);
        if (int'(tbl_idx) < min_idx) min_idx = int'(tbl_idx);
        if (int'(tbl_idx) > max_idx) max_idx = int'(tbl_idx);
        if (exp_q.size() != 0) checkOutput("mmcm_rst_held", mmcm_rst, 1);
      end
      if (error && !prev_err) begin
        err_cyc = cyc;
        mrst_at_err = mmcm_rst;
      end
      if (!mmcm_rst && prev_mrst) rel_cyc = cyc;
      if (done) done_cyc = cyc;
      prev_busy = busy;
      prev_err  = error;
      prev_mrst = mmcm_rst;
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    checks = 0;
    errors = 0;
    cyc = 0;
    rst = 1'b1;
    start = 1'b0;
    cfg_sel = 2'd0;
    mem_init_req = 1'b0;
    no_resp_en = 1'b0;
    no_resp_addr = 7'h00;
    never_lock = 1'b0;
    cur_cfg = 0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_error", error, 0);
    checkOutput("rst_tbl_idx", tbl_idx, 0);
    checkOutput("rst_daddr", drp_daddr, 0);
    checkOutput("rst_den", drp_den, 0);
    checkOutput("rst_dwe", drp_dwe, 0);
    checkOutput("rst_di", drp_di, 0);
    checkOutput("rst_mmcm_rst", mmcm_rst, 0);
    rst = 1'b0;
    repeat (110) @(negedge clk);

    $display("[TB] nominal sequence, cfg 1");
    applyStimulus(1, -1);
    checkOutput("busy_after_start", busy, 1);
    checkOutput("mmcm_rst_after_start", mmcm_rst, 1);
    waitDone(3000);
    checkOutput("nom_error", error, 0);
    checkOutput("nom_busy_at_done", busy, 0);
    start = 1'b1;
    cfg_sel = 2'd2;
    @(negedge clk);
    start = 1'b0;
    checkOutput("nom_done_pulse", done, 0);
    checkOutput("nom_reads", n_rd, 23);
    checkOutput("nom_writes", n_wr, 23);
    checkOutput("nom_min_idx", min_idx, 23);
    checkOutput("nom_max_idx", max_idx, 45);
    checkOutput("nom_queue_empty", exp_q.size(), 0);
    checkRange("nom_lock_wait", done_cyc - rel_cyc, 100, 115);
    @(negedge clk);
    checkOutput("start_at_done_ignored", busy, 0);

    $display("[TB] DRDY timeout on register 5, cfg 2");
    no_resp_en = 1'b1;
    no_resp_addr = 7'h0D;
    applyStimulus(2, 5);
    waitDone(3000);
    checkOutput("to_error", error, 1);
    checkOutput("to_busy", busy, 0);
    @(negedge clk);
    checkOutput("to_err_delay", err_cyc - last_den_cyc, 65);
    checkOutput("to_mmcm_rst_drop", mrst_at_err, 0);
    checkOutput("to_reads", n_rd, 6);
    checkOutput("to_writes", n_wr, 5);
    checkOutput("to_error_sticky", error, 1);
    no_resp_en = 1'b0;

    $display("[TB] LOCK timeout, cfg 0");
    never_lock = 1'b1;
    applyStimulus(0, -1);
    waitDone(4000);
    checkOutput("lk_error", error, 1);
    @(negedge clk);
    checkRange("lk_timeout_wait", done_cyc - rel_cyc, 995, 1010);
    checkOutput("lk_writes", n_wr, 23);
    never_lock = 1'b0;

    $display("[TB] start ignored mid-sequence, cfg 3");
    applyStimulus(3, -1);
    checkOutput("mid_error_cleared", error, 0);
    repeat (60) @(negedge clk);
    cfg_sel = 2'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(3000);
    checkOutput("mid_error", error, 0);
    @(negedge clk);
    checkOutput("mid_min_idx", min_idx, 69);
    checkOutput("mid_max_idx", max_idx, 91);
    checkOutput("mid_reads", n_rd, 23);
    checkOutput("mid_writes", n_wr, 23);

    $display("[TB] async reset during WAIT_WR, cfg 1");
    applyStimulus(1, -1);
    n = 0;
    while (!(drp_den && drp_dwe) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rr_write_seen", drp_den & drp_dwe, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rr_busy", busy, 0);
    checkOutput("rr_mmcm_rst", mmcm_rst, 0);
    checkOutput("rr_den", drp_den, 0);
    checkOutput("rr_tbl_idx", tbl_idx, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    repeat (6) @(negedge clk);
    applyStimulus(1, -1);
    waitDone(3000);
    checkOutput("rr_error", error, 0);
    @(negedge clk);
    checkOutput("rr_reads", n_rd, 23);
    checkOutput("rr_writes", n_wr, 23);
    checkOutput("rr_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
